// File: rtl/tlc_junction.sv
// tlc_junction: two-phase traffic light controller with pedestrian phase,
// emergency preemption and flashing mode.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   ped_req      pedestrian call (level or pulse), latched into ped_pending
//   emerg        emergency preempt (level)
//   flash_en     flash mode request (level)
//   ns_light     north-south lamp (RED=00, YEL=01, GRN=10, OFF=11)
//   ew_light     east-west lamp
//   ped_walk     walk indication, high only in PED
//   ped_pending  latched pedestrian call
//   state        current state code
//   cnt          cycles spent in current state (saturating)
//
// state | meaning
// NSG   | north-south green
// NSY   | north-south yellow
// AR1   | all-red clearance before east-west green
// EWG   | east-west green
// EWY   | east-west yellow
// AR2   | all-red clearance before pedestrian phase or north-south green
// PED   | pedestrian walk, all vehicle lamps red
// FLASH | flashing mode, ns yellow / ew red blinking against all-off
module tlc_junction #(
  parameter int CNT_W     = 8,
  parameter int T_GRN     = 10,
  parameter int T_MIN_GRN = 4,
  parameter int T_YEL     = 3,
  parameter int T_ALLRED  = 2,
  parameter int T_PED     = 6,
  parameter int T_FLASH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ped_req,
  input  logic             emerg,
  input  logic             flash_en,
  output logic [1:0]       ns_light,
  output logic [1:0]       ew_light,
  output logic             ped_walk,
  output logic             ped_pending,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cnt
);

  localparam int T_MAX = (1 << CNT_W) - 1;

  if (T_GRN < 1 || T_GRN > T_MAX || T_MIN_GRN < 1 || T_MIN_GRN > T_GRN ||
      T_YEL < 1 || T_YEL > T_MAX || T_ALLRED < 1 || T_ALLRED > T_MAX ||
      T_PED < 1 || T_PED > T_MAX || T_FLASH < 1 || T_FLASH > T_MAX) begin : g_cfg_err
    $error("tlc_junction: timing parameter out of range");
  end

  localparam logic [1:0] L_RED = 2'b00;
  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;
  localparam logic [1:0] L_OFF = 2'b11;

  // Terminal counts: the last cnt value spent in each timed state.
  localparam logic [CNT_W-1:0] GRN_LAST     = CNT_W'(T_GRN - 1);
  localparam logic [CNT_W-1:0] MIN_GRN_LAST = CNT_W'(T_MIN_GRN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST     = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST  = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] PED_LAST     = CNT_W'(T_PED - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST   = CNT_W'(T_FLASH - 1);

  typedef enum logic [2:0] {
    S_NSG   = 3'd0,
    S_NSY   = 3'd1,
    S_AR1   = 3'd2,
    S_EWG   = 3'd3,
    S_EWY   = 3'd4,
    S_AR2   = 3'd5,
    S_PED   = 3'd6,
    S_FLASH = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             ped_pending_q, ped_pending_d;
  logic [1:0]       ns_q, ns_d;
  logic [1:0]       ew_q, ew_d;
  logic             walk_q, walk_d;

  logic green_done;
  logic allred_done;

  // Green ends on full dwell, on preempt, or early for a pending walk call.
  assign green_done  = (cnt_q == GRN_LAST) || emerg ||
                       (ped_pending_q && (cnt_q >= MIN_GRN_LAST));
  assign allred_done = !emerg && (cnt_q >= ALLRED_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_NSG:   if (green_done) state_d = S_NSY;
      S_NSY:   if (cnt_q == YEL_LAST) state_d = S_AR1;
      S_AR1:   if (allred_done) state_d = S_EWG;
      S_EWG:   if (green_done) state_d = S_EWY;
      S_EWY:   if (cnt_q == YEL_LAST) state_d = S_AR2;
      S_AR2:   if (allred_done) state_d = ped_pending_q ? S_PED : S_NSG;
      S_PED: begin
        if (emerg)                  state_d = S_AR2;
        else if (cnt_q == PED_LAST) state_d = S_NSG;
      end
      S_FLASH: if (!flash_en) state_d = S_AR2;
      default: state_d = S_NSG;
    endcase
    if (flash_en && (state_q != S_FLASH)) state_d = S_FLASH;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if ((state_q == S_FLASH) && (cnt_q == FLASH_LAST))
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  // Blink phase restarts at 1 on every FLASH entry and is held at 1 elsewhere.
  always_comb begin
    phase_d = phase_q;
    if ((state_d != S_FLASH) || (state_q != S_FLASH))
      phase_d = 1'b1;
    else if (cnt_q == FLASH_LAST)
      phase_d = ~phase_q;
  end

  // Entry clear takes precedence over a same-cycle call.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if ((state_d == S_PED) || (state_d == S_FLASH))
      ped_pending_d = 1'b0;
    else if (ped_req && (state_q != S_PED) && (state_q != S_FLASH))
      ped_pending_d = 1'b1;
  end

  // Lamps decode the next state so they change in the same cycle as state.
  always_comb begin
    ns_d   = L_RED;
    ew_d   = L_RED;
    walk_d = 1'b0;
    case (state_d)
      S_NSG:   ns_d = L_GRN;
      S_NSY:   ns_d = L_YEL;
      S_EWG:   ew_d = L_GRN;
      S_EWY:   ew_d = L_YEL;
      S_PED:   walk_d = 1'b1;
      S_FLASH: begin
        if (phase_d) begin
          ns_d = L_YEL;
          ew_d = L_RED;
        end else begin
          ns_d = L_OFF;
          ew_d = L_OFF;
        end
      end
      default: begin
        ns_d = L_RED;
        ew_d = L_RED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_NSG;
      cnt_q         <= '0;
      phase_q       <= 1'b1;
      ped_pending_q <= 1'b0;
      ns_q          <= L_GRN;
      ew_q          <= L_RED;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      ped_pending_q <= ped_pending_d;
      ns_q          <= ns_d;
      ew_q          <= ew_d;
      walk_q        <= walk_d;
    end
  end

  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign ped_walk    = walk_q;
  assign ped_pending = ped_pending_q;
  assign state       = state_q;
  assign cnt         = cnt_q;

endmodule

// File: tb/tb_tlc_junction.sv
// tb_tlc_junction: directed testbench for tlc_junction with default parameters.
// Inputs change 1 ns after the rising edge; outputs are observed at the same point.
`timescale 1ns/1ps
module tb_tlc_junction;

  localparam logic [2:0] NSG = 3'd0, NSY = 3'd1, AR1 = 3'd2, EWG = 3'd3,
                         EWY = 3'd4, AR2 = 3'd5, PED = 3'd6, FLASH = 3'd7;
  localparam logic [1:0] RED = 2'b00, YEL = 2'b01, GRN = 2'b10, OFF = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ped_req = 1'b0;
  logic       emerg = 1'b0;
  logic       flash_en = 1'b0;
  logic [1:0] ns_light, ew_light;
  logic       ped_walk, ped_pending;
  logic [2:0] state;
  logic [7:0] cnt;

  int n_chk  = 0;
  int n_pass = 0;

  tlc_junction dut (
    .clk        (clk),
    .rst        (rst),
    .ped_req    (ped_req),
    .emerg      (emerg),
    .flash_en   (flash_en),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .ped_walk   (ped_walk),
    .ped_pending(ped_pending),
    .state      (state),
    .cnt        (cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d of %0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_ns(input logic [2:0] st);
    case (st)
      NSG:     return GRN;
      NSY:     return YEL;
      default: return RED;
    endcase
  endfunction

  function automatic logic [1:0] exp_ew(input logic [2:0] st);
    case (st)
      EWG:     return GRN;
      EWY:     return YEL;
      default: return RED;
    endcase
  endfunction

  // Checks one whole non-flash state dwell starting at cnt=0, n cycles long.
  task automatic run_state(input string tag, input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, " state"}, 32'(state), 32'(st));
      check({tag, " cnt"}, 32'(cnt), 32'(i));
      check({tag, " ns"}, 32'(ns_light), 32'(exp_ns(st)));
      check({tag, " ew"}, 32'(ew_light), 32'(exp_ew(st)));
      check({tag, " walk"}, 32'(ped_walk), 32'(st == PED));
      tick();
    end
  endtask

  // Leaves rst low with the DUT showing the reset-produced NSG, cnt=0 cycle.
  task automatic do_reset();
    rst = 1'b1;
    ped_req = 1'b0;
    emerg = 1'b0;
    flash_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    do_reset();
    check("rst state", 32'(state), 32'(NSG));
    check("rst cnt", 32'(cnt), 0);
    check("rst ns", 32'(ns_light), 32'(GRN));
    check("rst ew", 32'(ew_light), 32'(RED));
    check("rst walk", 32'(ped_walk), 0);
    check("rst pending", 32'(ped_pending), 0);

    // Free-running cycle, 30-cycle period, twice around
    for (int p = 0; p < 2; p++) begin
      run_state("cyc NSG", NSG, 10);
      run_state("cyc NSY", NSY, 3);
      run_state("cyc AR1", AR1, 2);
      run_state("cyc EWG", EWG, 10);
      run_state("cyc EWY", EWY, 3);
      run_state("cyc AR2", AR2, 2);
    end
    check("cyc wrap state", 32'(state), 32'(NSG));
    check("cyc wrap cnt", 32'(cnt), 0);

    // Pedestrian call pulse at NSG cnt=1
    do_reset();
    tick();
    check("ped nsg cnt1", 32'(cnt), 1);
    check("ped pending before", 32'(ped_pending), 0);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    check("ped pending set", 32'(ped_pending), 1);
    check("ped nsg cnt2", 32'(cnt), 2);
    tick();
    check("ped nsg cnt3 state", 32'(state), 32'(NSG));
    check("ped nsg cnt3", 32'(cnt), 3);
    tick();
    run_state("ped NSY", NSY, 3);
    run_state("ped AR1", AR1, 2);
    check("ped pending at EWG", 32'(ped_pending), 1);
    run_state("ped EWG", EWG, 4);
    run_state("ped EWY", EWY, 3);
    run_state("ped AR2", AR2, 2);
    check("ped pending cleared", 32'(ped_pending), 0);
    run_state("ped PED", PED, 6);
    check("ped after state", 32'(state), 32'(NSG));
    check("ped after cnt", 32'(cnt), 0);

    // Emergency during EWG cnt=5, held 10 edges
    do_reset();
    run_state("em NSG", NSG, 10);
    run_state("em NSY", NSY, 3);
    run_state("em AR1", AR1, 2);
    run_state("em EWG", EWG, 5);
    check("em EWG cnt5", 32'(cnt), 5);
    emerg = 1'b1;
    tick();
    run_state("em EWY", EWY, 3);
    run_state("em AR2 hold", AR2, 6);
    check("em AR2 cnt6 state", 32'(state), 32'(AR2));
    check("em AR2 cnt6", 32'(cnt), 6);
    emerg = 1'b0;
    tick();
    check("em release state", 32'(state), 32'(NSG));
    check("em release cnt", 32'(cnt), 0);

    // Flash mode for 20 cycles entered from NSY
    do_reset();
    run_state("fl NSG", NSG, 10);
    check("fl NSY state", 32'(state), 32'(NSY));
    flash_en = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      check("fl state", 32'(state), 32'(FLASH));
      check("fl cnt", 32'(cnt), 32'(k % 4));
      check("fl ns", 32'(ns_light), ((k / 4) % 2 == 0) ? 32'(YEL) : 32'(OFF));
      check("fl ew", 32'(ew_light), ((k / 4) % 2 == 0) ? 32'(RED) : 32'(OFF));
      if (k == 19) flash_en = 1'b0;
      tick();
    end
    run_state("fl AR2", AR2, 2);
    check("fl exit state", 32'(state), 32'(NSG));

    // Reset in the middle of PED
    do_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    repeat (20) tick();
    check("rp PED state", 32'(state), 32'(PED));
    check("rp PED cnt", 32'(cnt), 3);
    check("rp PED walk", 32'(ped_walk), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rp state", 32'(state), 32'(NSG));
    check("rp cnt", 32'(cnt), 0);
    check("rp walk", 32'(ped_walk), 0);
    check("rp pending", 32'(ped_pending), 0);
    check("rp ns", 32'(ns_light), 32'(GRN));

    // Emergency during PED, and a call during PED is ignored
    do_reset();
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    repeat (18) tick();
    check("pe PED state", 32'(state), 32'(PED));
    check("pe PED cnt", 32'(cnt), 1);
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    check("pe ignored call", 32'(ped_pending), 0);
    emerg = 1'b1;
    tick();
    check("pe AR2 state", 32'(state), 32'(AR2));
    check("pe AR2 walk", 32'(ped_walk), 0);
    repeat (3) tick();
    check("pe AR2 hold", 32'(state), 32'(AR2));
    check("pe AR2 cnt", 32'(cnt), 3);
    emerg = 1'b0;
    tick();
    check("pe exit state", 32'(state), 32'(NSG));

    // Flash has priority over emergency and pedestrian call
    do_reset();
    tick();
    flash_en = 1'b1;
    emerg = 1'b1;
    ped_req = 1'b1;
    tick();
    ped_req = 1'b0;
    check("pr state", 32'(state), 32'(FLASH));
    check("pr pending", 32'(ped_pending), 0);
    check("pr ns", 32'(ns_light), 32'(YEL));
    flash_en = 1'b0;
    emerg = 1'b0;
    tick();
    check("pr exit", 32'(state), 32'(AR2));

    // Counter saturation in AR1 under a 300-cycle emergency
    do_reset();
    run_state("sat NSG", NSG, 10);
    run_state("sat NSY", NSY, 3);
    check("sat AR1 state", 32'(state), 32'(AR1));
    emerg = 1'b1;
    for (int j = 1; j <= 300; j++) begin
      tick();
      if (j == 254) check("sat cnt 254", 32'(cnt), 254);
      if (j == 255) check("sat cnt 255", 32'(cnt), 255);
      if (j == 256) check("sat cnt hold", 32'(cnt), 255);
    end
    check("sat end state", 32'(state), 32'(AR1));
    check("sat end cnt", 32'(cnt), 255);
    emerg = 1'b0;
    tick();
    check("sat exit state", 32'(state), 32'(EWG));
    check("sat exit cnt", 32'(cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tlc_junction.md
TLC_JUNCTION -- requirements
Module: tlc_junction

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CNT_W 8 dwell counter width
  T_GRN 10 full green dwell, cycles
  T_MIN_GRN 4 minimum green when a pedestrian call is pending
  T_YEL 3 yellow dwell
  T_ALLRED 2 all-red clearance dwell
  T_PED 6 pedestrian walk dwell
  T_FLASH 4 flash half-period
REQ-002 Every T_* value SHALL be at least 1 and no more than 2^CNT_W-1, and T_MIN_GRN SHALL be no more than T_GRN; violation is a configuration error.
REQ-003 Ports, one per line (name, direction, width, meaning):
  clk in 1 clock, rising edge
  rst in 1 reset, synchronous, active-high
  ped_req in 1 pedestrian call, level or pulse
  emerg in 1 emergency preempt, level
  flash_en in 1 flash mode request, level
  ns_light out 2 north-south lamp
  ew_light out 2 east-west lamp
  ped_walk out 1 walk indication
  ped_pending out 1 latched pedestrian call
  state out 3 current state code
  cnt out CNT_W cycles spent in current state
REQ-004 Lamp encoding SHALL be RED=00, YEL=01, GRN=10, OFF=11.

Function
REQ-005 States and codes SHALL be NSG=0, NSY=1, AR1=2, EWG=3, EWY=4, AR2=5, PED=6, FLASH=7.
REQ-006 Lamp outputs SHALL be registered and decoded from state:
  NSG: ns GRN, ew RED
  NSY: ns YEL, ew RED
  EWG: ns RED, ew GRN
  EWY: ns RED, ew YEL
  AR1, AR2, PED: both RED
REQ-007 ped_walk SHALL be 1 only in PED.
REQ-008 cnt SHALL reset to 0 on every state change, increment by 1 in every other cycle, and saturate at all-ones.
REQ-009 Transition priority SHALL be: rst, then flash_en, then emerg, then pedestrian call, then timer.
REQ-010 In any state other than FLASH, flash_en=1 SHALL force FLASH on the next cycle.
REQ-011 NSG SHALL go to NSY when any of the following holds: cnt==T_GRN-1, emerg=1, or (ped_pending=1 and cnt>=T_MIN_GRN-1).
REQ-012 EWG SHALL go to EWY under the same conditions as NSG.
REQ-013 NSY SHALL go to AR1, and EWY SHALL go to AR2, when cnt==T_YEL-1; emerg SHALL NOT shorten yellow.
REQ-014 AR1 SHALL exit to EWG when cnt>=T_ALLRED-1 and emerg=0; it SHALL hold all-red while emerg=1.
REQ-015 AR2 SHALL exit when cnt>=T_ALLRED-1 and emerg=0, to PED if ped_pending=1, otherwise to NSG; it SHALL hold all-red while emerg=1.
REQ-016 PED SHALL go to NSG when cnt==T_PED-1, and SHALL go to AR2 on the next cycle if emerg=1.
REQ-017 ped_pending SHALL set on the cycle after ped_req=1 in any state except PED and FLASH.
REQ-018 ped_pending SHALL clear on entry to PED and on entry to FLASH; ped_req during PED or FLASH SHALL be ignored.
REQ-019 In FLASH, a blink phase bit SHALL be 1 on entry and SHALL toggle when cnt==T_FLASH-1, at which point cnt wraps to 0.
REQ-020 In FLASH with phase=1, ns SHALL be YEL and ew SHALL be RED; with phase=0, both SHALL be OFF.
REQ-021 FLASH SHALL exit to AR2 on the cycle after flash_en=0.
REQ-022 state and cnt SHALL be registered outputs that reflect the current state.

Reset
REQ-023 With rst=1 at a clock edge, the next cycle SHALL give state=NSG, cnt=0, ns=GRN, ew=RED, ped_walk=0, ped_pending=0, blink phase=1, overriding all other inputs and any operation in progress.

Verification
REQ-024 Reset release with all inputs 0 (default parameters) -> NSG 10 cycles, NSY 3, AR1 2, EWG 10, EWY 3, AR2 2, back to NSG; period 30 cycles, repeating.
REQ-025 ped_req pulse at NSG cnt=1 -> ped_pending=1 at cnt=2; NSY at cnt==3 (4 green cycles); EWG lasts 4 cycles; AR2 is followed by PED for 6 cycles with ped_walk=1; ped_pending clears entering PED; then NSG.
REQ-026 emerg=1 at EWG cnt=5, held 10 cycles -> EWY on the next cycle, full 3-cycle yellow, AR2 held until emerg falls; AR2 exits to NSG on the cycle after release, since cnt>=1 by then.
REQ-027 flash_en=1 for 20 cycles during NSY -> FLASH next cycle; ns alternates YEL/OFF and ew alternates RED/OFF every 4 cycles; after release, AR2 for 2 cycles, then NSG.
REQ-028 rst=1 for one cycle at PED cnt=3 -> next cycle state=NSG, cnt=0, ped_walk=0, ped_pending=0.
REQ-029 cnt saturation: T_ALLRED=2 with emerg held 300 cycles in AR1 (CNT_W=8) -> cnt holds at 255 with no wrap; EWG on the cycle after emerg falls.
